// File: rtl/vga_board_writer_if.sv
// CPU-side MMIO bus and display write-port signals of vga_board_writer.
// The master side belongs to the CPU or the bench. The slave side belongs to the writer.
interface vga_board_writer_if;
    logic [31:0] cpu_addr;
    logic        cpu_we;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic [31:0] vga_addr;
    logic        vga_we;
    logic [31:0] vga_wdata;
    logic        busy;

    modport master (
        output cpu_addr, cpu_we, cpu_wdata,
        input  cpu_rdata, vga_addr, vga_we, vga_wdata, busy
    );

    modport slave (
        input  cpu_addr, cpu_we, cpu_wdata,
        output cpu_rdata, vga_addr, vga_we, vga_wdata, busy
    );
endinterface

// File: rtl/vga_board_writer.sv
// Board display writer.
// Keeps a shadow copy of ten display slots: nine cells plus one status slot.
// Sends each changed slot to the display as one {tag, idx} word.
// Each word is held for HOLD_CYCLES cycles before the next word may go out.
module vga_board_writer #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_FF00,
    parameter int unsigned HOLD_CYCLES = 4,
    parameter logic [15:0] MAX_IDX     = 16'd9
) (
    input logic               clk,
    input logic               rst,
    vga_board_writer_if.slave bus
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t      state;
    logic [15:0] cnt;
    logic [15:0] shadow [10];
    logic [9:0]  dirty;
    logic        err;

    logic [31:0] offset;
    logic [3:0]  word;
    logic        in_window;
    logic        slot_hit;
    logic        ctrl_hit;
    logic        status_hit;
    logic        idx_legal;
    logic        sel_valid;
    logic [3:0]  sel_idx;
    logic        issue;
    logic [9:0]  set_mask;
    logic [9:0]  clr_mask;
    logic        busy_w;

    // Display tag of a slot: slot 0 is the status slot and is tagged 0xA.
    function automatic logic [15:0] tag_of(input logic [3:0] k);
        return (k == 4'd0) ? 16'h000A : {12'b0, k};
    endfunction

    // Decode the CPU address into slot, CTRL or STATUS hits.
    // Unaligned and out-of-window addresses hit nothing.
    always_comb begin
        // NOTE: every always_comb output is assigned before any branch, so no latch is inferred.
        offset     = bus.cpu_addr - BASE_ADDR;
        word       = offset[5:2];
        in_window  = (offset[1:0] == 2'b00) && (offset < 32'h30);
        slot_hit   = in_window && (word <= 4'd9);
        ctrl_hit   = in_window && (word == 4'd10);
        status_hit = in_window && (word == 4'd11);
        idx_legal  = (bus.cpu_wdata[15:0] <= MAX_IDX);
    end

    // Pick the lowest-numbered dirty slot as the next word to send.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = 4'd0;
        for (int k = 9; k >= 0; k--) begin
            if (dirty[k]) begin
                sel_valid = 1'b1;
                sel_idx   = 4'(k);
            end
        end
    end

    assign issue = (state == IDLE) && sel_valid;

    // Dirty-bit edits for this cycle.
    // A CPU set is applied after the scanner's clear, so the set wins.
    always_comb begin
        clr_mask = issue ? (10'b1 << sel_idx) : 10'b0;
        set_mask = 10'b0;
        if (bus.cpu_we && slot_hit && idx_legal) begin
            set_mask = 10'b1 << word;
        end else if (bus.cpu_we && ctrl_hit && bus.cpu_wdata[0]) begin
            set_mask = 10'h3FF;
        end
    end

    // Shadow slots, dirty bits and the sticky illegal-index flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the shadow array is reset explicitly because readback of an unwritten slot must return idx 0.
            for (int k = 0; k < 10; k++) begin
                shadow[k] <= 16'd0;
            end
            dirty <= 10'd0;
            err   <= 1'b0;
        end else begin
            dirty <= (dirty & ~clr_mask) | set_mask;
            if (bus.cpu_we && slot_hit) begin
                if (idx_legal) begin
                    shadow[word] <= bus.cpu_wdata[15:0];
                end else begin
                    err <= 1'b1;
                end
            end else if (bus.cpu_we && ctrl_hit && bus.cpu_wdata[1]) begin
                err <= 1'b0;
            end
        end
    end

    // Scanner FSM with registered display outputs.
    // HOLD returns to IDLE as cnt reaches 0, so issues are HOLD_CYCLES apart.
    // The minimum spacing is two cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every register updates together at the edge.
            state         <= IDLE;
            cnt           <= 16'd0;
            bus.vga_addr  <= 32'd0;
            bus.vga_we    <= 1'b0;
            bus.vga_wdata <= 32'd0;
        end else begin
            bus.vga_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        bus.vga_we    <= 1'b1;
                        bus.vga_wdata <= {tag_of(sel_idx), shadow[sel_idx]};
                        bus.vga_addr  <= BASE_ADDR + {26'd0, sel_idx, 2'b00};
                        cnt           <= 16'(HOLD_CYCLES - 1);
                        state         <= HOLD;
                    end
                end
                HOLD: begin
                    if (cnt <= 16'd1) begin
                        state <= IDLE;
                    end
                    cnt <= (cnt == 16'd0) ? 16'd0 : cnt - 16'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy_w   = (state != IDLE) || (dirty != 10'd0);
    assign bus.busy = busy_w;

    // Combinational register readback; 0 outside the window.
    always_comb begin
        bus.cpu_rdata = 32'd0;
        if (slot_hit) begin
            bus.cpu_rdata = {tag_of(word), shadow[word]};
        end else if (status_hit) begin
            bus.cpu_rdata = {20'd0, err, busy_w, dirty};
        end
    end

endmodule

// File: tb/tb_vga_board_writer.sv
// Self-checking bench for vga_board_writer.
// It runs a table of register vectors, hand-written timing sequences and a random phase.
// The random phase is checked against a slot-level display model.
module tb_vga_board_writer;

    localparam logic [31:0] BASE = 32'h0000_FF00;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    vga_board_writer_if bus ();

    vga_board_writer #(
        .BASE_ADDR  (BASE),
        .HOLD_CYCLES(4),
        .MAX_IDX    (16'd9)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Words seen on the display port, plus a model of what the display shows.
    logic [31:0] mon_word [$];
    logic [31:0] mon_addr [$];
    int          mon_cyc  [$];
    logic [31:0] exp_q    [$];
    logic [15:0] disp     [10];
    int          bad_words = 0;

    always @(negedge clk) begin
        int k;
        if (bus.vga_we) begin
            mon_word.push_back(bus.vga_wdata);
            mon_addr.push_back(bus.vga_addr);
            mon_cyc.push_back(cyc);
            k = -1;
            if (bus.vga_wdata[31:16] == 16'h000A) k = 0;
            else if (bus.vga_wdata[31:16] >= 16'd1 && bus.vga_wdata[31:16] <= 16'd9) k = int'(bus.vga_wdata[31:16]);
            if (k < 0 || bus.vga_addr != BASE + 32'(4 * k) || bus.vga_wdata[15:0] > 16'd9) bad_words++;
            else disp[k] = bus.vga_wdata[15:0];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        bus.cpu_we = 1'b0;
        bus.cpu_addr = 32'd0;
        bus.cpu_wdata = 32'd0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        mon_word.delete();
        mon_addr.delete();
        mon_cyc.delete();
        exp_q.delete();
        for (int k = 0; k < 10; k++) disp[k] = 16'd0;
    endtask

    // One-cycle store: driven now, sampled at the next rising edge, returns at the following negedge.
    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
        bus.cpu_addr = a;
        bus.cpu_wdata = d;
        bus.cpu_we = 1'b1;
        @(negedge clk);
        bus.cpu_we = 1'b0;
    endtask

    task automatic cpu_read(input logic [31:0] a, output logic [31:0] d);
        bus.cpu_we = 1'b0;
        bus.cpu_addr = a;
        #1;
        d = bus.cpu_rdata;
    endtask

    task automatic wait_idle(input string name, input int max);
        int n = 0;
        while (bus.busy && n < max) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle_in_time"}, {31'd0, n < max}, 32'd1);
    endtask

    // Compare monitored words against exp_q; consecutive words must be 4 cycles apart.
    task automatic compare_mon(input string name);
        check({name, "_count"}, 32'(mon_word.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < mon_word.size(); i++) begin
            check($sformatf("%s_word%0d", name, i), mon_word[i], exp_q[i]);
            if (i > 0) check($sformatf("%s_gap%0d", name, i), 32'(mon_cyc[i] - mon_cyc[i-1]), 32'd4);
        end
    endtask

    typedef struct {
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [31:0] raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [10];
    logic [15:0] shadow_m [10];
    logic        err_m;
    logic [31:0] rd;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{BASE + 32'h14, 32'h0000_0003, BASE + 32'h14, 32'h0005_0003};
        vecs[1] = '{BASE + 32'h00, 32'hFFFF_0007, BASE + 32'h00, 32'h000A_0007};
        vecs[2] = '{BASE + 32'h24, 32'h0000_0009, BASE + 32'h24, 32'h0009_0009};
        vecs[3] = '{BASE + 32'h24, 32'h0000_000A, BASE + 32'h24, 32'h0009_0009};
        vecs[4] = '{BASE + 32'h16, 32'h0000_0001, BASE + 32'h14, 32'h0005_0003};
        vecs[5] = '{BASE + 32'h30, 32'h0000_0001, BASE + 32'h30, 32'h0000_0000};
        vecs[6] = '{BASE - 32'h4,  32'h0000_0001, BASE - 32'h4,  32'h0000_0000};
        vecs[7] = '{BASE + 32'h2C, 32'h0000_0005, BASE + 32'h04, 32'h0001_0000};
        vecs[8] = '{BASE + 32'h08, 32'h0000_0000, BASE + 32'h08, 32'h0002_0000};
        vecs[9] = '{BASE + 32'h20, 32'h0000_0004, BASE + 32'h20, 32'h0008_0004};

        bus.cpu_we = 1'b0;
        bus.cpu_addr = 32'd0;
        bus.cpu_wdata = 32'd0;

        // Reset state and the single-store latency.
        reset_dut();
        check("rst_vga_addr", bus.vga_addr, 32'd0);
        check("rst_vga_we", {31'd0, bus.vga_we}, 32'd0);
        check("rst_vga_wdata", bus.vga_wdata, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        cpu_read(BASE + 32'h2C, rd);
        check("rst_status", rd, 32'd0);
        @(negedge clk);
        cpu_write(BASE + 32'h14, 32'h0000_0003);
        check("s5_no_early_we", {31'd0, bus.vga_we}, 32'd0);
        @(negedge clk);
        check("s5_we", {31'd0, bus.vga_we}, 32'd1);
        check("s5_wdata", bus.vga_wdata, 32'h0005_0003);
        check("s5_addr", bus.vga_addr, BASE + 32'h14);
        @(negedge clk);
        @(negedge clk);
        check("s5_busy_still_high", {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        check("s5_busy_fallen", {31'd0, bus.busy}, 32'd0);

        // Register table.
        reset_dut();
        for (int i = 0; i < 10; i++) begin
            cpu_write(vecs[i].waddr, vecs[i].wdata);
            cpu_read(vecs[i].raddr, rd);
            check($sformatf("vec%0d_readback", i), rd, vecs[i].exp);
        end
        wait_idle("vec", 200);

        // Slot 5 is in HOLD while slots 9, 2 and 0 are stored, so all three go out lowest-first.
        reset_dut();
        cpu_write(BASE + 32'h14, 32'd6);
        cpu_write(BASE + 32'h24, 32'd1);
        cpu_write(BASE + 32'h08, 32'd2);
        cpu_write(BASE + 32'h00, 32'd3);
        wait_idle("order", 200);
        exp_q = '{32'h0005_0006, 32'h000A_0003, 32'h0002_0002, 32'h0009_0001};
        compare_mon("order");

        // A store landing on the same edge that sends the slot: set beats clear.
        reset_dut();
        cpu_write(BASE + 32'h0C, 32'd7);
        cpu_write(BASE + 32'h0C, 32'd8);
        wait_idle("setclr", 200);
        exp_q = '{32'h0003_0007, 32'h0003_0008};
        compare_mon("setclr");

        // Rewrite slot 4 in the cycle its vga_we is high.
        reset_dut();
        cpu_write(BASE + 32'h10, 32'd7);
        @(negedge clk);
        cpu_write(BASE + 32'h10, 32'd8);
        wait_idle("rewrite", 200);
        exp_q = '{32'h0004_0007, 32'h0004_0008};
        compare_mon("rewrite");

        // An illegal index is dropped and sets err; CTRL bit1 clears err.
        reset_dut();
        cpu_write(BASE + 32'h04, 32'h0000_000C);
        repeat (6) @(negedge clk);
        check("illegal_no_we", 32'(mon_word.size()), 32'd0);
        cpu_read(BASE + 32'h04, rd);
        check("illegal_slot1", rd, 32'h0001_0000);
        cpu_read(BASE + 32'h2C, rd);
        check("illegal_status", rd, 32'h0000_0800);
        @(negedge clk);
        cpu_write(BASE + 32'h28, 32'h2);
        cpu_read(BASE + 32'h2C, rd);
        check("err_cleared", rd, 32'd0);

        // Forced refresh of all ten slots.
        reset_dut();
        cpu_write(BASE + 32'h28, 32'h1);
        begin
            int n = 0;
            while (bus.busy && n < 200) begin
                n++;
                @(negedge clk);
            end
            check("refresh_busy_cycles", 32'(n), 32'd40);
        end
        for (int k = 0; k < 10; k++) exp_q.push_back((k == 0) ? 32'h000A_0000 : 32'(k) << 16);
        compare_mon("refresh");

        // Reset asserted two cycles into HOLD abandons the transfer.
        reset_dut();
        cpu_write(BASE + 32'h1C, 32'd5);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_vga_addr", bus.vga_addr, 32'd0);
        check("midrst_vga_we", {31'd0, bus.vga_we}, 32'd0);
        check("midrst_vga_wdata", bus.vga_wdata, 32'd0);
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        cpu_read(BASE + 32'h2C, rd);
        check("midrst_status", rd, 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("midrst_no_resend", 32'(mon_word.size()), 32'd1);

        // Random stores and CTRL writes against a slot-level model.
        reset_dut();
        for (int k = 0; k < 10; k++) shadow_m[k] = 16'd0;
        err_m = 1'b0;
        for (int i = 0; i < 120; i++) begin
            int gap;
            int k;
            logic [31:0] d;
            gap = $urandom_range(0, 5);
            if ($urandom_range(0, 9) == 0) begin
                d = 32'($urandom_range(0, 3));
                cpu_write(BASE + 32'h28, d);
                if (d[1]) err_m = 1'b0;
            end else begin
                k = $urandom_range(0, 9);
                d = ($urandom() & 32'hFFFF_0000) | 32'($urandom_range(0, 11));
                cpu_write(BASE + 32'(4 * k), d);
                if (d[15:0] <= 16'd9) shadow_m[k] = d[15:0];
                else err_m = 1'b1;
            end
            repeat (gap) @(negedge clk);
        end
        wait_idle("rand", 400);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("rand_display%0d", k), {16'd0, disp[k]}, {16'd0, shadow_m[k]});
            cpu_read(BASE + 32'(4 * k), rd);
            check($sformatf("rand_readback%0d", k), rd, {(k == 0) ? 16'h000A : 16'(k), shadow_m[k]});
        end
        cpu_read(BASE + 32'h2C, rd);
        check("rand_status", rd, {20'd0, err_m, 11'd0});
        check("word_format", 32'(bad_words), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
